mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage plus the EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core. It consumes the ALU result and store data leaving EX and drives the data-memory request/response handshake. It performs store byte-lane placement and load extraction with sign/zero extension. It produces the MEM- and WB-side values (`ALUResult_mem`, `RegWriteData_wb`, destinations, write enables) that EX forwarding reads, and stalls the front of the pipe while a memory access is outstanding.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `ALUResult_ex`  in  32: ALU result or effective address from EX.
- `MemWriteData_ex`  in  32: forwarded rs2 data from EX.
- `rdAddr_ex`  in  5: destination register.
- `RegWrite_ex`  in  1: instruction writes rd.
- `MemRead_ex`  in  1: instruction is a load.
- `MemWrite_ex`  in  1: instruction is a store.
- `MemFunct_ex`  in  3: funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALUResult_mem`  out  32: EX/MEM ALU result, forwarded to EX.
- `rdAddr_mem`  out  5: destination register in MEM.
- `RegWrite_mem`  out  1: write enable in MEM.
- `RegWriteData_wb`  out  32: final writeback data.
- `rdAddr_wb`  out  5: destination register in WB.
- `RegWrite_wb`  out  1: write enable in WB.
- `stall_mem`  out  1: freeze PC, IF/ID, ID/EX and the EX/MEM register.
- `misalign_err`  out  1: one-cycle pulse on a misaligned access.
- `dmem_req`  out  1: memory request valid.
- `dmem_we`  out  1: write (1) or read (0).
- `dmem_addr`  out  32: word address; bits [1:0] are always 0.
- `dmem_wdata`  out  32: lane-aligned store data.
- `dmem_be`  out  4: byte enables.
- `dmem_gnt`  in  1: request accepted this cycle.
- `dmem_rvalid`  in  1: read data valid.
- `dmem_rdata`  in  32: read data (word).

## Operation
- EX/MEM register loads on every edge with `stall_mem`=0 and holds when it is 1.
- An access is `MemRead|MemWrite` in EX/MEM.
- Misaligned accesses:
  - H/HU with addr[0]=1, or W with addr[1:0]≠0, is misaligned.
  - No request is issued.
  - `misalign_err` pulses one cycle.
  - The instruction enters WB with `RegWrite_wb`=0.
- Store lane placement:
  - Byte: `be`=0001<<addr[1:0], data replicated ×4.
  - Half: `be`=0011<<addr[1:0], data replicated ×2.
  - Word: `be`=1111.
- Load extraction: select the byte or half at addr[1:0], then sign- or zero-extend per funct3.
- FSM states:
  - IDLE: `dmem_req`=1 iff an aligned access is present and not yet done.
    - `gnt`=1 with a store: access done.
    - `gnt`=1 with a load: go to RESP.
    - `gnt`=0: stay in IDLE, request held stable.
  - RESP: `dmem_req`=0. On `rvalid`, capture the extracted data, access done, return to IDLE.
- `stall_mem` = access present AND NOT done this cycle.
- `dmem_rvalid` in IDLE is ignored.
- MEM/WB register:
  - Loads `rdAddr`, `RegWrite` and the writeback data (load data if `MemRead`, else `ALUResult_mem`) when MEM is not stalled.
  - While stalled, a bubble is loaded (`RegWrite_wb`=0).
- Writes to x0 are suppressed: `RegWrite_*` is forced to 0 when rd=0.

## Timing
- All outputs are registered except `dmem_*`, `stall_mem` and `misalign_err`, which are combinational from the EX/MEM register and FSM state.
- Reset values: all EX/MEM and MEM/WB fields are 0 (bubble), FSM is IDLE, `dmem_req`=0, `stall_mem`=0.
- Latency EX→WB:
  - Non-memory instruction: 2 edges.
  - Store with same-cycle `gnt`: 2 edges, no stall.
  - Load with same-cycle `gnt` and next-cycle `rvalid`: 1 stall cycle.
  - Each extra wait cycle adds one stall cycle.
- Load-use hazards are not handled here. `ALUResult_mem` carries the address for loads, and the hazard unit must stall consumers.
- Reset asserted mid-access: FSM returns to IDLE immediately, and any later `rvalid` is ignored.

## Structure
- Shared package `core_pkg`: funct3 size constants, FSM state enum, `XLEN`.
- One sub-module, `load_store_align`, containing the combinational lane placement, byte-enable generation, load extraction and misalignment detect.
- The FSM and pipeline registers live in the top.

## Test plan
- ALU op, rd=5, result 0x1234 → `ALUResult_mem`=0x1234 after 1 edge; `RegWriteData_wb`=0x1234 and `RegWrite_wb`=1 after 2 edges; `stall_mem` never asserts.
- SB, addr 0x103, data 0xAB, `gnt` same cycle → `dmem_addr`=0x100, `be`=1000, `wdata`=0xABABABAB, no stall.
- LB, addr 0x102, `rdata`=0x00800000, `gnt` immediate, `rvalid` 3 cycles later → `stall_mem` high 3 cycles, `RegWriteData_wb`=0xFFFFFF80. The same case with LBU gives 0x00000080.
- LW, addr 0x106 → no `dmem_req`, `misalign_err` high 1 cycle, `RegWrite_wb`=0.
- SW with `gnt` held low 4 cycles → request fields stable throughout, `stall_mem` high 4 cycles, EX/MEM contents unchanged.
- `rst_n` pulsed while in RESP → FSM IDLE, `stall_mem`=0; a late `rvalid` causes no writeback.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: datapath width, load/store size codes, MEM FSM states.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 size codes for loads and stores
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic {
    StIdle,
    StResp
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane placement for stores, extraction/extension for loads, and
// misalignment detection. Only the low two address bits matter here.
module load_store_align
  import core_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misalignment: halves need addr[0]=0, words need addr[1:0]=0.
  always_comb begin
    misaligned_o = 1'b0;
    case (funct_i)
      Funct3H, Funct3Hu: misaligned_o = addr_i[0];
      Funct3W:           misaligned_o = (addr_i != 2'b00);
      default:           misaligned_o = 1'b0;
    endcase
  end

  // Store lane placement: replicate the datum and enable only the addressed lanes.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Load extraction: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'b00: byte_sel = rdata_i[7:0];
      2'b01: byte_sel = rdata_i[15:8];
      2'b10: byte_sel = rdata_i[23:16];
      2'b11: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (funct_i)
      Funct3B:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
      Funct3H:  load_data_o = {{16{half_sel[15]}}, half_sel};
      Funct3Bu: load_data_o = {24'h0, byte_sel};
      Funct3Hu: load_data_o = {16'h0, half_sel};
      default:  load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage with EX/MEM and MEM/WB pipeline registers and the data-memory handshake FSM.
module mem_access_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ALUResult_ex,
  input  logic [XLEN-1:0] MemWriteData_ex,
  input  logic [4:0]      rdAddr_ex,
  input  logic            RegWrite_ex,
  input  logic            MemRead_ex,
  input  logic            MemWrite_ex,
  input  logic [2:0]      MemFunct_ex,
  output logic [XLEN-1:0] ALUResult_mem,
  output logic [4:0]      rdAddr_mem,
  output logic            RegWrite_mem,
  output logic [XLEN-1:0] RegWriteData_wb,
  output logic [4:0]      rdAddr_wb,
  output logic            RegWrite_wb,
  output logic            stall_mem,
  output logic            misalign_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  import core_pkg::*;

  // EX/MEM register fields
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] st_data_q;
  logic [4:0]      rd_q;
  logic            regwrite_q;
  logic            memread_q;
  logic            memwrite_q;
  logic [2:0]      funct_q;

  // MEM/WB register fields
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_regwrite_q, wb_regwrite_d;

  mem_state_e state_q, state_d;

  logic            access;
  logic            misaligned_raw;
  logic            misaligned;
  logic            done;
  logic [XLEN-1:0] load_data;

  load_store_align u_align (
    .addr_i       (alu_q[1:0]),
    .funct_i      (funct_q),
    .wdata_i      (st_data_q),
    .rdata_i      (dmem_rdata),
    .wdata_o      (dmem_wdata),
    .be_o         (dmem_be),
    .load_data_o  (load_data),
    .misaligned_o (misaligned_raw)
  );

  assign access       = memread_q | memwrite_q;
  assign misaligned   = access & misaligned_raw;
  assign misalign_err = misaligned;
  assign dmem_we      = memwrite_q;
  assign dmem_addr    = {alu_q[XLEN-1:2], 2'b00};

  assign ALUResult_mem   = alu_q;
  assign rdAddr_mem      = rd_q;
  assign RegWrite_mem    = regwrite_q;
  assign RegWriteData_wb = wb_data_q;
  assign rdAddr_wb       = wb_rd_q;
  assign RegWrite_wb     = wb_regwrite_q;

  // EX/MEM register: advances unless MEM is stalled; x0 writes are dropped on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q      <= '0;
      st_data_q  <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      funct_q    <= '0;
    end else if (!stall_mem) begin
      alu_q      <= ALUResult_ex;
      st_data_q  <= MemWriteData_ex;
      rd_q       <= rdAddr_ex;
      regwrite_q <= RegWrite_ex & (rdAddr_ex != 5'd0);
      memread_q  <= MemRead_ex;
      memwrite_q <= MemWrite_ex;
      funct_q    <= MemFunct_ex;
    end
  end

  // Handshake FSM: request in IDLE, wait for read data in RESP; misaligned accesses finish at once.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    done     = 1'b0;
    case (state_q)
      StIdle: begin
        if (access) begin
          if (misaligned) begin
            done = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
              if (memwrite_q) begin
                done = 1'b1;
              end else begin
                state_d = StResp;
              end
            end
          end
        end
      end
      StResp: begin
        if (dmem_rvalid) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    stall_mem = access & ~done;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // MEM/WB next state: bubble while stalled, misaligned accesses never write back.
  always_comb begin
    wb_data_d     = memread_q ? load_data : alu_q;
    wb_rd_d       = rd_q;
    wb_regwrite_d = regwrite_q & ~misaligned;
    if (stall_mem) begin
      wb_rd_d       = 5'd0;
      wb_regwrite_d = 1'b0;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
    end else begin
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
    end
  end

endmodule
